// File: rtl/noc_async_fifo_tx.sv
// Producer half of the NoC clock-domain-crossing FIFO: accepts packets in the NoC domain,
// exports a Gray write pointer and the entry addressed by the consumer's Gray read pointer.
module noc_async_fifo_tx #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned AWIDTH      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic [DATA_WIDTH-1:0] pkt_data_i,
    input  logic                  pkt_valid_i,
    output logic                  pkt_ready_o,
    output logic [DATA_WIDTH-1:0] fifo_data_o,
    output logic [AWIDTH:0]       fifo_waddr_o,
    input  logic [AWIDTH:0]       fifo_raddr_i,
    output logic [AWIDTH:0]       fill_level_o
);
    localparam int unsigned PW    = AWIDTH + 1;
    localparam int unsigned DEPTH = 1 << AWIDTH;
    // Gray write pointer equals the synced read pointer with its two MSBs inverted when full.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (AWIDTH - 1);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = g;
        for (int unsigned i = 1; i < PW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    logic [PW-1:0]         wbin;
    logic [PW-1:0]         wgray;
    logic [PW-1:0]         wbin_next;
    logic [PW-1:0]         rsync [SYNC_STAGES];
    logic [PW-1:0]         rs;
    logic                  full;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rs        = rsync[SYNC_STAGES-1];
    assign full      = (wgray == (rs ^ FULL_MASK));
    assign wr_en     = pkt_valid_i && !full;
    assign wbin_next = wbin + PW'(1);

    // Write pointer advances on the same edge the entry is stored.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wbin  <= '0;
            wgray <= '0;
        end else if (wr_en) begin
            wbin  <= wbin_next;
            wgray <= bin2gray(wbin_next);
        end
    end

    // Read-pointer synchroniser from the consumer domain.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                rsync[i] <= '0;
            end
        end else begin
            rsync[0] <= fifo_raddr_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                rsync[i] <= rsync[i-1];
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wbin[AWIDTH-1:0]] <= pkt_data_i;
        end
    end

    assign fifo_data_o  = mem[AWIDTH'(gray2bin(fifo_raddr_i))];
    assign fifo_waddr_o = wgray;
    assign pkt_ready_o  = !full;
    assign fill_level_o = wbin - gray2bin(rs);

endmodule

// File: tb/tb_noc_async_fifo_tx.sv
// Self-checking bench for noc_async_fifo_tx against a count-based FIFO model.
module tb_noc_async_fifo_tx;
    localparam int unsigned DW    = 128;
    localparam int unsigned AW    = 3;
    localparam int unsigned SS    = 2;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic [DW-1:0] fifo_data;
    logic [PW-1:0] waddr;
    logic [PW-1:0] raddr;
    logic [PW-1:0] fill;

    int errors = 0;
    int checks = 0;

    // Model: total writes, consumer read count, consumer count as seen after SS edges.
    int            wr_m;
    int            rd_m;
    int            sp_m [SS];
    logic [DW-1:0] mem_m [DEPTH];

    always #5 clk = ~clk;

    noc_async_fifo_tx #(.DATA_WIDTH(DW), .AWIDTH(AW), .SYNC_STAGES(SS)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .pkt_data_i   (data),
        .pkt_valid_i  (valid),
        .pkt_ready_o  (ready),
        .fifo_data_o  (fifo_data),
        .fifo_waddr_o (waddr),
        .fifo_raddr_i (raddr),
        .fill_level_o (fill)
    );

    function automatic logic [PW-1:0] gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic int seen_rd();
        return sp_m[SS-1];
    endfunction

    function automatic logic exp_ready();
        return (wr_m - seen_rd()) < int'(DEPTH);
    endfunction

    function automatic logic [PW-1:0] exp_fill();
        return PW'(wr_m - seen_rd());
    endfunction

    task automatic model_reset();
        wr_m = 0;
        rd_m = 0;
        for (int i = 0; i < int'(SS); i++) sp_m[i] = 0;
    endtask

    task automatic set_rd(input int n);
        rd_m  = n;
        raddr = gray(n);
    endtask

    // Advance one clock edge, updating the model with the pre-edge inputs.
    task automatic tick();
        if (valid && exp_ready()) begin
            mem_m[wr_m % int'(DEPTH)] = data;
            wr_m++;
        end
        for (int i = int'(SS) - 1; i > 0; i--) sp_m[i] = sp_m[i-1];
        sp_m[0] = rd_m;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        valid   = 1'b1;
        data    = {$urandom, $urandom, $urandom, $urandom};
        raddr   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (waddr !== 4'b0000) begin errors++; $display("FAIL reset_waddr: got %b expected 0000", waddr); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++;
        if (fill !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
        valid   = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if (waddr !== 4'b0000) begin errors++; $display("FAIL reset_nowrite: got %b expected 0000", waddr); end
    endtask

    task automatic test_fill();
        set_rd(0);
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            data  = DW'(160 + i);
            tick();
            checks++;
            if (waddr !== gray(wr_m)) begin errors++; $display("FAIL fill_waddr: got %b expected %b", waddr, gray(wr_m)); end
            checks++;
            if (fill !== exp_fill()) begin errors++; $display("FAIL fill_level: got %0d expected %0d", fill, exp_fill()); end
            checks++;
            if (ready !== exp_ready()) begin errors++; $display("FAIL fill_ready: got %b expected %b", ready, exp_ready()); end
        end
        checks++;
        if (waddr !== 4'b1100) begin errors++; $display("FAIL fill_full_waddr: got %b expected 1100", waddr); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready: got %b expected 0", ready); end
        checks++;
        if (fill !== 4'd8) begin errors++; $display("FAIL fill_full_level: got %0d expected 8", fill); end
        data = DW'(168);
        repeat (3) begin
            tick();
            checks++;
            if (waddr !== 4'b1100) begin errors++; $display("FAIL overflow_waddr: got %b expected 1100", waddr); end
            checks++;
            if (ready !== 1'b0) begin errors++; $display("FAIL overflow_ready: got %b expected 0", ready); end
        end
        valid = 1'b0;
    endtask

    task automatic test_readout();
        for (int n = 1; n <= 4; n++) begin
            set_rd(n);
            #1;
            checks++;
            if (fifo_data !== DW'(160 + n)) begin errors++; $display("FAIL readout_data: got %h expected %h", fifo_data, DW'(160 + n)); end
            tick();
            checks++;
            if (fill !== exp_fill()) begin errors++; $display("FAIL readout_fill: got %0d expected %0d", fill, exp_fill()); end
        end
    endtask

    task automatic test_drain();
        for (int n = 5; n <= 8; n++) begin
            set_rd(n);
            tick();
            checks++;
            if (fill !== exp_fill()) begin errors++; $display("FAIL drain_fill: got %0d expected %0d", fill, exp_fill()); end
            checks++;
            if (ready !== exp_ready()) begin errors++; $display("FAIL drain_ready: got %b expected %b", ready, exp_ready()); end
        end
        checks++;
        if (fill !== 4'd1) begin errors++; $display("FAIL drain_one_edge: got %0d expected 1", fill); end
        tick();
        checks++;
        if (fill !== 4'd0) begin errors++; $display("FAIL drain_two_edges_fill: got %0d expected 0", fill); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL drain_two_edges_ready: got %b expected 1", ready); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 20; k++) begin
            valid = 1'b1;
            data  = {$urandom, $urandom, $urandom, $urandom};
            if (wr_m - 2 > rd_m) set_rd(rd_m + 1);
            #1;
            if (rd_m < wr_m) begin
                checks++;
                if (fifo_data !== mem_m[rd_m % int'(DEPTH)]) begin errors++; $display("FAIL wrap_data: entry %0d got %h expected %h", rd_m, fifo_data, mem_m[rd_m % int'(DEPTH)]); end
            end
            checks++;
            if (ready !== 1'b1) begin errors++; $display("FAIL wrap_ready: got %b expected 1", ready); end
            tick();
            checks++;
            if (waddr !== gray(wr_m)) begin errors++; $display("FAIL wrap_waddr: got %b expected %b", waddr, gray(wr_m)); end
            if (wr_m == 15) begin
                checks++;
                if (waddr !== 4'b1000) begin errors++; $display("FAIL wrap_waddr15: got %b expected 1000", waddr); end
            end
            if (wr_m == 16) begin
                checks++;
                if (waddr !== 4'b0000) begin errors++; $display("FAIL wrap_waddr16: got %b expected 0000", waddr); end
            end
            checks++;
            if (fill !== exp_fill()) begin errors++; $display("FAIL wrap_fill: got %0d expected %0d", fill, exp_fill()); end
        end
        valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 400; k++) begin
            valid = ($urandom_range(0, 9) < 7);
            data  = {$urandom, $urandom, $urandom, $urandom};
            if (rd_m < wr_m && $urandom_range(0, 9) < 4) set_rd(rd_m + 1);
            #1;
            if (rd_m < wr_m) begin
                checks++;
                if (fifo_data !== mem_m[rd_m % int'(DEPTH)]) begin errors++; $display("FAIL rand_data: entry %0d got %h expected %h", rd_m, fifo_data, mem_m[rd_m % int'(DEPTH)]); end
            end
            checks++;
            if (ready !== exp_ready()) begin errors++; $display("FAIL rand_ready: got %b expected %b", ready, exp_ready()); end
            tick();
            checks++;
            if (waddr !== gray(wr_m)) begin errors++; $display("FAIL rand_waddr: got %b expected %b", waddr, gray(wr_m)); end
            checks++;
            if (fill !== exp_fill()) begin errors++; $display("FAIL rand_fill: got %0d expected %0d", fill, exp_fill()); end
        end
        valid = 1'b0;
    endtask

    task automatic test_midburst_reset();
        logic [DW-1:0] fresh;
        #2 reset_n = 1'b0;
        model_reset();
        raddr = '0;
        #2 reset_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data  = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        valid = 1'b0;
        checks++;
        if (fill !== 4'd5) begin errors++; $display("FAIL midrst_queued: got %0d expected 5", fill); end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (waddr !== 4'b0000) begin errors++; $display("FAIL midrst_waddr: got %b expected 0000", waddr); end
        checks++;
        if (fill !== 4'd0) begin errors++; $display("FAIL midrst_fill: got %0d expected 0", fill); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b expected 1", ready); end
        model_reset();
        set_rd(0);
        #2 reset_n = 1'b1;
        fresh = ~mem_m[0];
        valid = 1'b1;
        data  = fresh;
        tick();
        valid = 1'b0;
        checks++;
        if (waddr !== 4'b0001) begin errors++; $display("FAIL midrst_first_waddr: got %b expected 0001", waddr); end
        checks++;
        if (fifo_data !== fresh) begin errors++; $display("FAIL midrst_first_data: got %h expected %h", fifo_data, fresh); end
        checks++;
        if (fill !== 4'd1) begin errors++; $display("FAIL midrst_first_fill: got %0d expected 1", fill); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_readout();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_midburst_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
